// File: rtl/square_position_ctrl_if.sv
// Button/frame inputs and square-position outputs between the board I/O and the
// square position controller.
interface square_position_ctrl_if;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       screenEnd;
    logic [9:0] squareX;
    logic [8:0] squareY;
    logic       moved;

    modport master (
        output left, right, up, down, screenEnd,
        input  squareX, squareY, moved
    );

    modport slave (
        input  left, right, up, down, screenEnd,
        output squareX, squareY, moved
    );
endinterface

// File: rtl/square_position_ctrl.sv
// Debounces four push-buttons and steps the overlay square's top-left corner once
// per frame, clamped to the visible area.
module square_position_ctrl #(
    parameter int unsigned WIDTH           = 640,
    parameter int unsigned HEIGHT          = 480,
    parameter int unsigned SIZE            = 20,
    parameter int unsigned STEP            = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned INIT_X          = 310,
    parameter int unsigned INIT_Y          = 230
) (
    input logic                   clk,
    input logic                   reset,
    square_position_ctrl_if.slave bus
);
    localparam int unsigned XMAX = WIDTH - 1 - SIZE;
    localparam int unsigned YMAX = HEIGHT - 1 - SIZE;
    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [10:0]   XMAX11   = 11'(XMAX);
    localparam logic [10:0]   YMAX11   = 11'(YMAX);
    localparam logic [10:0]   STEP11   = 11'(STEP);
    localparam logic [9:0]    INIT_X10 = (INIT_X > XMAX) ? 10'(XMAX) : 10'(INIT_X);
    localparam logic [8:0]    INIT_Y9  = (INIT_Y > YMAX) ? 9'(YMAX) : 9'(INIT_Y);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Button bit order: 0 left, 1 right, 2 up, 3 down.
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    deb_q,   deb_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [2:0]    se_q,    se_d;
    logic [9:0]    x_q,     x_d;
    logic [8:0]    y_q,     y_d;
    logic          moved_q, moved_d;
    logic          tick_c;
    logic [10:0]   x11_c, y11_c;

    // Synchronize and debounce each button independently.
    always_comb begin
        sync1_d = {bus.down, bus.up, bus.right, bus.left};
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Rising edge of the resynchronized end-of-frame level.
    assign se_d   = {se_q[1:0], bus.screenEnd};
    assign tick_c = se_q[1] & ~se_q[2];
    assign x11_c  = {1'b0, x_q};
    assign y11_c  = {2'b0, y_q};

    // Per-frame move with clamping; uses the debounced state from before this edge.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick_c) begin
            case ({deb_q[1], deb_q[0]})
                2'b01:   x_d = (x11_c < STEP11) ? 10'd0 : 10'(x11_c - STEP11);
                2'b10:   x_d = ((x11_c + STEP11) > XMAX11) ? 10'(XMAX) : 10'(x11_c + STEP11);
                default: x_d = x_q;
            endcase
            case ({deb_q[3], deb_q[2]})
                2'b01:   y_d = (y11_c < STEP11) ? 9'd0 : 9'(y11_c - STEP11);
                2'b10:   y_d = ((y11_c + STEP11) > YMAX11) ? 9'(YMAX) : 9'(y11_c + STEP11);
                default: y_d = y_q;
            endcase
        end
        moved_d = (x_d != x_q) || (y_d != y_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            se_q    <= '0;
            x_q     <= INIT_X10;
            y_q     <= INIT_Y9;
            moved_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            se_q    <= se_d;
            x_q     <= x_d;
            y_q     <= y_d;
            moved_q <= moved_d;
        end
    end

    assign bus.squareX = x_q;
    assign bus.squareY = y_q;
    assign bus.moved   = moved_q;
endmodule

// File: tb/tb_square_position_ctrl.sv
// Scoreboard bench: four controller instances with different start positions,
// short debounce; expected positions queued per move, checked on each moved pulse.
module tb_square_position_ctrl;
    localparam int unsigned N = 4;
    localparam int unsigned IX [N] = '{310, 7, 617, 700};
    localparam int unsigned IY [N] = '{230, 3, 457, 500};

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst [N];
    logic [3:0] btn [N];   // {down, up, right, left}
    logic       se  [N];
    logic [9:0] sx  [N];
    logic [8:0] sy  [N];
    logic       mv  [N];

    exp_t exp_q [N][$];
    int   tests_run = 0;
    int   failed    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : u
        square_position_ctrl_if bus ();
        assign bus.left      = btn[g][0];
        assign bus.right     = btn[g][1];
        assign bus.up        = btn[g][2];
        assign bus.down      = btn[g][3];
        assign bus.screenEnd = se[g];
        assign sx[g]         = bus.squareX;
        assign sy[g]         = bus.squareY;
        assign mv[g]         = bus.moved;

        square_position_ctrl #(
            .DEBOUNCE_CYCLES(4),
            .INIT_X         (IX[g]),
            .INIT_Y         (IY[g])
        ) dut (
            .clk  (clk),
            .reset(rst[g]),
            .bus  (bus.slave)
        );

        // Monitor: every moved pulse must match the next queued position.
        always @(negedge clk) begin
            if (mv[g]) begin
                tests_run++;
                if (exp_q[g].size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_move inst%0d got (%0d,%0d) expected no move",
                             g, sx[g], sy[g]);
                end else begin
                    exp_t e;
                    e = exp_q[g].pop_front();
                    if (sx[g] !== e.x || sy[g] !== e.y) begin
                        failed++;
                        $display("FAIL move_pos inst%0d got (%0d,%0d) expected (%0d,%0d)",
                                 g, sx[g], sy[g], e.x, e.y);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_move(input int i, input int x, input int y);
        exp_t e;
        e.x = 10'(x);
        e.y = 9'(y);
        exp_q[i].push_back(e);
    endtask

    task automatic frame(input int i);
        se[i] = 1'b1;
        step(4);
        se[i] = 1'b0;
        step(6);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1;
            btn[i] = 4'b0;
            se[i]  = 1'b0;
        end
        step(3);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        step(1);

        chk("reset_x0", int'(sx[0]), 310);
        chk("reset_y0", int'(sy[0]), 230);
        chk("reset_moved0", int'(mv[0]), 0);
        chk("reset_x1", int'(sx[1]), 7);
        chk("reset_y1", int'(sy[1]), 3);
        chk("reset_x2", int'(sx[2]), 617);
        chk("reset_y2", int'(sy[2]), 457);
        chk("init_clamp_x3", int'(sx[3]), 619);
        chk("init_clamp_y3", int'(sy[3]), 459);

        // No buttons: frames never move the square.
        for (int f = 0; f < 5; f++) frame(0);
        chk("idle_x0", int'(sx[0]), 310);
        chk("idle_y0", int'(sy[0]), 230);

        // Left glitch of 3 cycles is shorter than the debounce window.
        btn[0][0] = 1'b1;
        step(3);
        btn[0][0] = 1'b0;
        step(4);
        for (int f = 0; f < 10; f++) frame(0);
        chk("glitch_x0", int'(sx[0]), 310);

        // Hold right; check exact tick latency on the first frame.
        btn[0][1] = 1'b1;
        step(10);
        expect_move(0, 315, 230);
        se[0] = 1'b1;
        step(1);                              // s1 captures 1 here
        chk("lat_edge1_x0", int'(sx[0]), 310);
        step(1);
        chk("lat_edge1b_x0", int'(sx[0]), 310);
        step(1);
        chk("lat_edge2_x0", int'(sx[0]), 315);
        chk("lat_moved0", int'(mv[0]), 1);
        step(1);
        chk("lat_moved_off0", int'(mv[0]), 0);
        se[0] = 1'b0;
        step(6);
        for (int f = 1; f <= 3; f++) begin
            expect_move(0, 315 + 5 * f, 230);
            frame(0);
        end
        chk("hold_x0", int'(sx[0]), 330);
        btn[0][1] = 1'b0;
        step(10);

        // Reset with down mid-debounce (counter at 2), release with down still held.
        btn[0][3] = 1'b1;
        step(4);
        rst[0] = 1'b1;
        step(2);
        rst[0] = 1'b0;
        chk("midrst_x0", int'(sx[0]), 310);
        chk("midrst_y0", int'(sy[0]), 230);
        chk("midrst_moved0", int'(mv[0]), 0);
        frame(0);                             // tick lands before debounce restarts fully
        chk("midrst_nomove_y0", int'(sy[0]), 230);
        expect_move(0, 310, 235);
        frame(0);
        chk("midrst_move_y0", int'(sy[0]), 235);

        // Clamp low with a diagonal move.
        btn[1] = 4'b0101;
        step(10);
        expect_move(1, 2, 0);
        frame(1);
        chk("clamp_lo1_x", int'(sx[1]), 2);
        chk("clamp_lo1_y", int'(sy[1]), 0);
        expect_move(1, 0, 0);
        frame(1);
        frame(1);
        chk("clamp_lo3_x", int'(sx[1]), 0);
        chk("clamp_lo3_y", int'(sy[1]), 0);

        // Clamp high, then conflicting left+right, then clamp on Y.
        btn[2] = 4'b0010;
        step(10);
        expect_move(2, 619, 457);
        frame(2);
        chk("clamp_hi_x2", int'(sx[2]), 619);
        btn[2] = 4'b0011;
        step(10);
        frame(2);
        chk("conflict_x2", int'(sx[2]), 619);
        btn[2] = 4'b1000;
        step(10);
        expect_move(2, 619, 459);
        frame(2);
        chk("clamp_hi_y2", int'(sy[2]), 459);
        frame(2);
        chk("clamp_hi_hold_y2", int'(sy[2]), 459);

        step(5);
        for (int i = 0; i < N; i++) chk($sformatf("pending_moves%0d", i), exp_q[i].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule

// File: doc/square_position_ctrl.md
Name: square_position_ctrl

Overview:
- Upstream stage of the VGA display path. Turns four raw push-button inputs into the registered top-left coordinate (squareX, squareY) of the 21x21-pixel overlay square that the VGA controller draws.
- Buttons are synchronized and debounced. The position moves by STEP pixels once per frame, on the screenEnd strobe, and is clamped to the visible 640x480 area.
- Runs entirely on the 100 MHz system clk. screenEnd is produced in the 25 MHz pixel domain and is resynchronized internally.

Parameters:
- WIDTH, 640, visible screen width in pixels
- HEIGHT, 480, visible screen height in pixels
- SIZE, 20, square spans x..x+SIZE and y..y+SIZE inclusive (21 px)
- STEP, 5, pixels moved per frame per axis
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles (10 ms) needed to accept a button change
- INIT_X, 310, reset X position
- INIT_Y, 230, reset Y position

Ports:
- clk  input  1  100 MHz system clock
- reset  input  1  synchronous, active-high reset
- left  input  1  raw asynchronous button, move -X
- right  input  1  raw asynchronous button, move +X
- up  input  1  raw asynchronous button, move -Y
- down  input  1  raw asynchronous button, move +Y
- screenEnd  input  1  end-of-frame level from the 25 MHz timing generator (asynchronous to clk)
- squareX  output  10  registered X of the square's left edge
- squareY  output  9  registered Y of the square's top edge
- moved  output  1  one-cycle pulse, high in the cycle after squareX or squareY changed

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising clk edge.
- Reset values: squareX=INIT_X, squareY=INIT_Y, moved=0. All synchronizer flops, debounced states and counters are cleared to 0. Reset takes priority over every other event and aborts any debounce or pending move in progress.
- Limits: XMAX = WIDTH-1-SIZE (619); YMAX = HEIGHT-1-SIZE (459).
- Button conditioning, applied independently to each of the four buttons:
  - 2-flop synchronizer.
  - Debounce: a per-button counter, width $clog2(DEBOUNCE_CYCLES+1).
  - While the synchronized value equals the debounced state, the counter holds at 0.
  - While it differs, the counter increments each cycle. When the counter reaches DEBOUNCE_CYCLES-1, the debounced state takes the synchronized value on that edge and the counter clears.
  - Any reversal before that point clears the counter, so glitches shorter than DEBOUNCE_CYCLES are ignored.
- Frame tick:
  - screenEnd passes through flops s1, s2, s3; tick = s2 & ~s3.
  - If s1 first captures 1 at edge k, the position register updates at edge k+2.
  - Exactly one tick per screenEnd rising edge, regardless of how long screenEnd stays high.
- Move rule, evaluated only on tick, using the debounced states:
  - X: left only, newX = (squareX < STEP) ? 0 : squareX-STEP.
  - X: right only, newX = (squareX > XMAX-STEP) ? XMAX : squareX+STEP.
  - X: both left and right, or neither, X holds.
  - Y follows the same rules with up/down and YMAX.
  - The X and Y axes update in the same cycle. A diagonal move is legal.
  - All arithmetic is done at 11 bits so that no intermediate value wraps. Outputs are never outside [0,XMAX] and [0,YMAX].
- Hold behaviour: a button held across N ticks moves the square N*STEP pixels, until the clamp is reached. Without a tick, the position never changes.
- moved:
  - High for exactly one cycle, in the cycle following an edge where the position register changed value.
  - A tick that leaves the position unchanged (clamped, or no button pressed) does not assert moved.
- Tick and debounce in the same cycle: if a debounced state changes on the same edge that tick is evaluated, the move uses the pre-update debounced state.
- Out-of-range parameters: if INIT_X > XMAX or INIT_Y > YMAX, the reset value is clamped to XMAX / YMAX.

Test Plan:
- Reset: DEBOUNCE_CYCLES=4; assert reset 3 cycles with buttons low -> squareX=310, squareY=230, moved=0. Then toggle screenEnd 5 times -> position unchanged, moved never asserted.
- Debounce and move:
  - Hold right steady.
  - After debounce completes, pulse screenEnd high for 4 clk -> squareX=315 exactly 2 edges after s1 captures 1, moved high for 1 cycle.
  - 3 further frames -> squareX=330.
- Glitch rejection: DEBOUNCE_CYCLES=4; pulse left high for 3 cycles only, then 10 frames -> squareX stays 310.
- Clamp low: reset with INIT_X=7, INIT_Y=3; hold left+up, run 1 frame -> (2,0)... next frame -> (0,0) with moved=1; third frame -> (0,0) with moved=0.
- Clamp high and conflicts:
  - INIT_X=617; hold right, 1 frame -> squareX=619.
  - Hold left+right together -> X holds.
  - Hold down at INIT_Y=457, 1 frame -> squareY=459.
- Reset mid-operation: hold down with the debounce counter at 2 of 4, assert reset, then release reset with down still held -> position=INIT. The debounce restarts from 0 and needs a full 4 stable cycles before the first move.
